elevator_call_panel: RTL

Landing call panel for the two-floor elevator: the requester end of the `call0/call1` ↔ `open/floor0/floor1` interface that the elevator FSM responds to. It synchronizes and optionally debounces two raw push-buttons and latches one request per floor. It holds `callN_o` high until the elevator reports doors open at that floor, drives per-floor lamps, and flags requests left unserved too long.

---
 rtl/elevator_call_panel.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/elevator_call_panel.sv
// -----------------------------------------------------------------------------
// elevator_call_panel
//
// Landing call panel for a two-floor elevator. Each floor button is brought into
// the clock domain by a two-flop synchronizer, optionally debounced, and turned
// into a one-cycle press pulse. A press latches one request per floor. The
// request is held on callN_o until the elevator reports doors open at that
// floor. The lamp stays lit until the doors close again. A per-floor wait
// counter flags requests that have gone unserved for too long.
//
// Build option:
//   ELEVATOR_CALL_PANEL_DEBOUNCE_EN  defined   -> debounce filter after the
//                                                synchronizer
//                                    undefined -> synchronizer output is used
//                                                directly; DEBOUNCE_CYCLES is
//                                                ignored
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles needed to flip the filtered
//                    level (>= 1)
//   TIMEOUT_CYCLES   pending cycles before stuck_o asserts (>= 1)
//
// Ports:
//   clk_i     in   system clock, rising edge
//   rst_ni    in   asynchronous active-low reset
//   btn0_i    in   raw floor-0 button (asynchronous, active-high)
//   btn1_i    in   raw floor-1 button (asynchronous, active-high)
//   open_i    in   doors open, from the elevator FSM
//   floor0_i  in   cabin at floor 0, from the elevator FSM
//   floor1_i  in   cabin at floor 1, from the elevator FSM
//   call0_o   out  floor-0 request to the elevator FSM
//   call1_o   out  floor-1 request to the elevator FSM
//   lamp0_o   out  floor-0 request lamp
//   lamp1_o   out  floor-1 request lamp
//   stuck_o   out  a request has been pending for TIMEOUT_CYCLES or more
//
// All outputs are decoded from registers only.
// -----------------------------------------------------------------------------
module elevator_call_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn0_i,
    input  logic btn1_i,
    input  logic open_i,
    input  logic floor0_i,
    input  logic floor1_i,
    output logic call0_o,
    output logic call1_o,
    output logic lamp0_o,
    output logic lamp1_o,
    output logic stuck_o
);

    localparam int                WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVING = 2'd2
    } state_t;

    logic [1:0] w_btn;
    logic [1:0] w_floor;
    logic [1:0] w_call;
    logic [1:0] w_lamp;
    logic [1:0] w_stuck;

    assign w_btn   = {btn1_i, btn0_i};
    assign w_floor = {floor1_i, floor0_i};

    // The two floors are completely independent; each gets its own copy of
    // the button path, request FSM and wait counter.
    for (genvar g = 0; g < 2; g++) begin : g_floor
        logic              r_sync1;
        logic              r_sync2;
        logic              w_level;
        logic              r_prev;
        logic              w_press;
        logic              w_here;
        state_t            r_state;
        state_t            w_state_nxt;
        logic [WAIT_W-1:0] r_wait;
        logic [WAIT_W-1:0] w_wait_nxt;

        // Two-flop synchronizer for the asynchronous button.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= w_btn[g];
                r_sync2 <= r_sync1;
            end
        end

`ifdef ELEVATOR_CALL_PANEL_DEBOUNCE_EN
        localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
        localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

        logic [DB_W-1:0] r_db_cnt;
        logic            r_filt;

        // The counter holds the number of disagreeing cycles already seen, so
        // the level flips on the edge where that count would reach
        // DEBOUNCE_CYCLES. Any agreeing cycle restarts the count.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_db_cnt <= '0;
                r_filt   <= 1'b0;
            end else if (r_sync2 == r_filt) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_cnt <= '0;
                r_filt   <= ~r_filt;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end

        assign w_level = r_filt;
`else
        assign w_level = r_sync2;
`endif

        // Rising-edge detector. r_prev clears on reset, so a button held
        // through reset release is seen as a fresh press.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_prev <= 1'b0;
            end else begin
                r_prev <= w_level;
            end
        end

        assign w_press = w_level & ~r_prev;
        assign w_here  = open_i & w_floor[g];

        // Request FSM and wait counter state.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state <= ST_IDLE;
                r_wait  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_wait  <= w_wait_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_wait_nxt  = '0;
            case (r_state)
                ST_IDLE: begin
                    // Pressing while the doors are already open here is
                    // served on the spot without raising a call.
                    if (w_press) begin
                        w_state_nxt = w_here ? ST_SERVING : ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (w_here) begin
                        w_state_nxt = ST_SERVING;
                    end
                end
                ST_SERVING: begin
                    if (!open_i) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            // Count only cycles spent in PENDING: the entry edge leaves the
            // counter at 0 and the exit edge clears it, so stuck drops on
            // the same edge the call drops.
            if ((r_state == ST_PENDING) && (w_state_nxt == ST_PENDING)) begin
                w_wait_nxt = (r_wait == WAIT_MAX) ? r_wait : r_wait + 1'b1;
            end
        end

        assign w_call[g]  = (r_state == ST_PENDING);
        assign w_lamp[g]  = (r_state != ST_IDLE);
        assign w_stuck[g] = (r_wait == WAIT_MAX);
    end

    assign call0_o = w_call[0];
    assign call1_o = w_call[1];
    assign lamp0_o = w_lamp[0];
    assign lamp1_o = w_lamp[1];
    assign stuck_o = |w_stuck;

endmodule
